// File: rtl/cmplx_div_pkg.sv
// Shared widths, state encoding and result helpers for complex_div_seq.
// CMPLX_DIV_ROUND_EN selects round-half-away-from-zero instead of truncation.
package cmplx_div_pkg;

    localparam int IN_W      = 4;
    localparam int OUT_W     = 9;
    localparam int FRAC_BITS = 4;
    localparam int NUM_W     = 9;
    localparam int DEN_W     = 8;
    localparam int CNT_W     = 4;

`ifdef CMPLX_DIV_ROUND_EN
    localparam int ITERS = 13;
    localparam int SHIFT = FRAC_BITS + 1;
`else
    localparam int ITERS = 12;
    localparam int SHIFT = FRAC_BITS;
`endif

    // One quotient bit per iteration, so the dividend is exactly ITERS bits wide.
    localparam int DVD_W = ITERS;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        DIV_R,
        DIV_I,
        DONE
    } state_t;

    function automatic logic [DVD_W-1:0] abs_shift(input logic signed [NUM_W-1:0] n);
        logic [NUM_W-1:0] m;
        m = n[NUM_W-1] ? -n : n;
        return DVD_W'(m) << SHIFT;
    endfunction

    function automatic logic signed [OUT_W-1:0] apply_sign(input logic [DVD_W-1:0] q,
                                                           input logic neg);
        logic [OUT_W-1:0] mag;
`ifdef CMPLX_DIV_ROUND_EN
        // One extra fraction bit: adding half an output LSB rounds the magnitude away from zero.
        mag = OUT_W'((q + DVD_W'(1)) >> 1);
`else
        mag = OUT_W'(q);
`endif
        return neg ? -mag : mag;
    endfunction

endpackage

// File: rtl/seq_udiv.sv
// Unsigned restoring divider: load captures operands, each step retires one quotient bit.
// q_next exposes the quotient after the current step so the caller can reload on the last step.
module seq_udiv
    import cmplx_div_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic [DVD_W-1:0] dividend,
    input  logic [DEN_W-1:0] divisor,
    output logic [DVD_W-1:0] q_next
);

    logic [DVD_W-1:0] q;
    logic [DEN_W-1:0] rem;
    logic [DEN_W-1:0] dvs;
    logic [DEN_W:0]   trial;
    logic [DEN_W-1:0] diff;
    logic [DEN_W-1:0] rem_next;
    logic             ge;

    // NOTE: every variable is given a value on every path here, so no latch is inferred.
    always_comb begin
        trial    = {rem, q[DVD_W-1]};
        ge       = trial >= {1'b0, dvs};
        // The remainder stays below the divisor after a subtract, so 8-bit wrap is exact.
        diff     = trial[DEN_W-1:0] - dvs;
        rem_next = ge ? diff : trial[DEN_W-1:0];
        q_next   = {q[DVD_W-2:0], ge};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q   <= '0;
            rem <= '0;
            dvs <= '0;
        end else if (load) begin
            q   <= dividend;
            rem <= '0;
            dvs <= divisor;
        end else if (step) begin
            q   <= q_next;
            rem <= rem_next;
        end
    end

endmodule

// File: rtl/complex_div_seq.sv
// Sequential complex divider z = (a+jb)/(c+jd), Q5.4 result, one shared divider.
// Rounding mode is selected by CMPLX_DIV_ROUND_EN (see cmplx_div_pkg).
module complex_div_seq
    import cmplx_div_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic signed [IN_W-1:0]  a,
    input  logic signed [IN_W-1:0]  b,
    input  logic signed [IN_W-1:0]  c,
    input  logic signed [IN_W-1:0]  d,
    output logic                    busy,
    output logic                    done,
    output logic signed [OUT_W-1:0] z_r,
    output logic signed [OUT_W-1:0] z_i,
    output logic                    div_zero
);

    state_t                  state;
    logic signed [IN_W-1:0]  a_q, b_q, c_q, d_q;
    logic signed [NUM_W-1:0] num_i_q;
    logic                    neg_r;
    logic [CNT_W-1:0]        cnt;
    logic signed [OUT_W-1:0] z_r_tmp;

    logic signed [NUM_W-1:0] a9, b9, c9, d9;
    logic signed [DEN_W-1:0] c8, d8;
    logic signed [NUM_W-1:0] num_r_c, num_i_c;
    logic [DEN_W-1:0]        den_c;
    logic                    last;
    logic                    div_load, div_step;
    logic [DVD_W-1:0]        dividend, q_next;

    always_comb begin
        a9       = NUM_W'(a_q);
        b9       = NUM_W'(b_q);
        c9       = NUM_W'(c_q);
        d9       = NUM_W'(d_q);
        c8       = DEN_W'(c_q);
        d8       = DEN_W'(d_q);
        num_r_c  = a9 * c9 + b9 * d9;
        num_i_c  = b9 * c9 - a9 * d9;
        den_c    = c8 * c8 + d8 * d8;
        last     = (cnt == CNT_W'(ITERS - 1));
        // The real-part divide is loaded straight from SETUP; the imaginary one on DIV_R's last step.
        div_load = (state == SETUP) || (state == DIV_R && last);
        div_step = (state == DIV_R) || (state == DIV_I);
        dividend = (state == SETUP) ? abs_shift(num_r_c) : abs_shift(num_i_q);
    end

    seq_udiv u_div (
        .clk      (clk),
        .rst      (rst),
        .load     (div_load),
        .step     (div_step),
        .dividend (dividend),
        .divisor  (den_c),
        .q_next   (q_next)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            z_r      <= '0;
            z_i      <= '0;
            z_r_tmp  <= '0;
            a_q      <= '0;
            b_q      <= '0;
            c_q      <= '0;
            d_q      <= '0;
            num_i_q  <= '0;
            neg_r    <= 1'b0;
            cnt      <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q   <= a;
                        b_q   <= b;
                        c_q   <= c;
                        d_q   <= d;
                        busy  <= 1'b1;
                        state <= SETUP;
                    end
                end
                SETUP: begin
                    neg_r   <= num_r_c[NUM_W-1];
                    num_i_q <= num_i_c;
                    cnt     <= '0;
                    if (den_c == '0) begin
                        z_r      <= '0;
                        z_i      <= '0;
                        div_zero <= 1'b1;
                        done     <= 1'b1;
                        state    <= DONE;
                    end else begin
                        state <= DIV_R;
                    end
                end
                DIV_R: begin
                    cnt <= last ? '0 : cnt + 1'b1;
                    if (last) begin
                        z_r_tmp <= apply_sign(q_next, neg_r);
                        state   <= DIV_I;
                    end
                end
                DIV_I: begin
                    cnt <= last ? '0 : cnt + 1'b1;
                    if (last) begin
                        z_r      <= z_r_tmp;
                        z_i      <= apply_sign(q_next, num_i_q[NUM_W-1]);
                        div_zero <= 1'b0;
                        done     <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_complex_div_seq.sv
// Self-checking bench for complex_div_seq: scoreboard of modelled results, directed operations.
// Honours CMPLX_DIV_ROUND_EN the same way the design does.
module tb_complex_div_seq;

`ifdef CMPLX_DIV_ROUND_EN
    localparam int TB_ITERS = 13;
`else
    localparam int TB_ITERS = 12;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic signed [3:0] a = '0, b = '0, c = '0, d = '0;
    logic              busy, done, div_zero;
    logic signed [8:0] z_r, z_i;

    typedef struct {
        logic signed [8:0] zr;
        logic signed [8:0] zi;
        logic              dz;
        int                lat;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    complex_div_seq dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .a        (a),
        .b        (b),
        .c        (c),
        .d        (d),
        .busy     (busy),
        .done     (done),
        .z_r      (z_r),
        .z_i      (z_i),
        .div_zero (div_zero)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic logic signed [8:0] model_q(input int num, input int den);
        int an;
        int mag;
        an = (num < 0) ? -num : num;
`ifdef CMPLX_DIV_ROUND_EN
        mag = ((an * 32) / den + 1) / 2;
`else
        mag = (an * 16) / den;
`endif
        return 9'((num < 0) ? -mag : mag);
    endfunction

    task automatic scramble();
        a = 4'($urandom);
        b = 4'($urandom);
        c = 4'($urandom);
        d = 4'($urandom);
    endtask

    // Runs one division; pulse_at >= 0 raises start during busy, start_in_done raises it in DONE.
    task automatic do_op(input string tag, input int ia, input int ib, input int ic, input int id,
                         input int pulse_at, input bit start_in_done);
        exp_t e;
        int   nr, ni, dn, k;
        bit   seen;
        nr = ia * ic + ib * id;
        ni = ib * ic - ia * id;
        dn = ic * ic + id * id;
        if (dn == 0) begin
            e.zr = '0; e.zi = '0; e.dz = 1'b1; e.lat = 1;
        end else begin
            e.zr = model_q(nr, dn); e.zi = model_q(ni, dn); e.dz = 1'b0; e.lat = 2 * TB_ITERS + 1;
        end
        sb.push_back(e);

        @(negedge clk);
        a = 4'(ia); b = 4'(ib); c = 4'(ic); d = 4'(id);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        seen  = 1'b0;
        for (k = 0; k < 60; k++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (k == 0) check({tag, "_busy"}, 32'(busy), 1);
            start = (k == pulse_at);
            scramble();
            @(negedge clk);
        end
        start = 1'b0;
        e = sb.pop_front();
        if (!seen) begin
            check({tag, "_timeout"}, 0, 1);
        end else begin
            check({tag, "_latency"}, k, e.lat);
            check({tag, "_z_r"}, z_r, e.zr);
            check({tag, "_z_i"}, z_i, e.zi);
            check({tag, "_div_zero"}, 32'(div_zero), 32'(e.dz));
        end
        start = start_in_done;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_done_pulse"}, 32'(done), 0);
        check({tag, "_idle"}, 32'(busy), 0);
    endtask

    initial begin
        int dones;

        repeat (2) @(negedge clk);
        check("reset_busy", 32'(busy), 0);
        check("reset_done", 32'(done), 0);
        check("reset_z_r", z_r, 0);
        check("reset_z_i", z_i, 0);
        check("reset_div_zero", 32'(div_zero), 0);
        rst = 1'b0;

        do_op("op_3_2_1_1", 3, 2, 1, 1, -1, 1'b0);
        do_op("op_2_0_3_0", 2, 0, 3, 0, -1, 1'b0);
        do_op("op_zero_div", 5, -3, 0, 0, -1, 1'b0);
        do_op("op_clear_dz", 1, 1, 1, 0, -1, 1'b0);
        do_op("op_m8_m8", -8, -8, 1, 0, 5, 1'b1);

        dones = 0;
        repeat (30) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("no_extra_done", dones, 0);

        do_op("op_mix1", -7, 5, 3, -2, -1, 1'b0);
        do_op("op_mix2", 7, 7, -8, -8, -1, 1'b0);
        do_op("op_mix3", 0, -1, 0, 5, -1, 1'b0);
        do_op("op_mix4", 1, -8, -8, 1, -1, 1'b0);
        do_op("op_mix5", -8, -8, -8, -8, -1, 1'b0);
        do_op("op_mix6", 1, 1, 3, 1, -1, 1'b0);
        do_op("op_zero_again", -1, 7, 0, 0, -1, 1'b0);

        // Abort a normal operation ten cycles in.
        @(negedge clk);
        a = 4'sd3; b = -4'sd4; c = 4'sd2; d = 4'sd1;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst   = 1'b1;
        start = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        check("abort_busy", 32'(busy), 0);
        check("abort_done", 32'(done), 0);
        check("abort_z_r", z_r, 0);
        check("abort_z_i", z_i, 0);
        check("abort_div_zero", 32'(div_zero), 0);
        dones = 0;
        repeat (30) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("abort_no_done", dones, 0);

        do_op("op_after_abort", 3, 2, 1, 1, -1, 1'b0);

        check("scoreboard_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/complex_div_seq.md
COMPLEX_DIV_SEQ -- requirements
Module: complex_div_seq

Interface
REQ-001 clk  input  1  rising-edge clock for all state.
REQ-002 rst  input  1  synchronous, active-high reset.
REQ-003 start  input  1  request a division; sampled only in IDLE.
REQ-004 a, b  input  4 each  dividend a+jb, signed two's complement.
REQ-005 c, d  input  4 each  divisor c+jd, signed two's complement.
REQ-006 busy  output  1  high in every state except IDLE.
REQ-007 done  output  1  one-cycle pulse; results valid in that cycle.
REQ-008 z_r, z_i  output  9 each  quotient real/imag, signed, Q5.4 (4 fraction bits).
REQ-009 div_zero  output  1  set with done when c = d = 0.

Function
REQ-010 Computation SHALL be z = (a+jb)/(c+jd): num_r = a*c + b*d, num_i = b*c - a*d, both 9-bit signed; den = c*c + d*d, 8-bit unsigned, range 0..128.
REQ-011 The FSM SHALL use the states IDLE, SETUP, DIV_R, DIV_I and DONE.
REQ-012 In IDLE, a start sampled high at edge N SHALL capture a, b, c and d and move the FSM to SETUP.
REQ-013 SETUP SHALL register num_r, num_i and den, then go to DIV_R; if den = 0 it SHALL go to DONE instead.
REQ-014 Each divide SHALL be sign-magnitude: dividend = |num| << 4 (12 bits) divided by den over 12 restoring iterations, one per cycle; the quotient SHALL be negated when num < 0.
REQ-015 Truncation SHALL be toward zero.
REQ-016 DIV_R SHALL produce z_r and DIV_I SHALL produce z_i, each taking exactly ITERS cycles.
REQ-017 Normal latency: start at edge N SHALL give done high in the cycle after edge N+25.
REQ-018 Zero-divisor latency: start at edge N SHALL give done high in the cycle after edge N+1, with z_r = z_i = 0 and div_zero = 1.
REQ-019 DONE SHALL last exactly one cycle, then return to IDLE; a start in that DONE cycle SHALL be ignored.
REQ-020 start SHALL be ignored while busy; inputs changing during busy SHALL NOT affect the result.
REQ-021 z_r, z_i and div_zero SHALL update only when entering DONE and SHALL hold until the next DONE.
REQ-022 div_zero SHALL clear on the next normal completion.
REQ-023 |z_r| and |z_i| never exceed 8.0 (128 LSB) for 4-bit inputs, so no saturation logic is required.

Reset
REQ-024 When rst is high at a clock edge, the FSM SHALL go to IDLE and busy, done, div_zero, z_r and z_i SHALL all be 0.
REQ-025 A reset in any state, including mid-division, SHALL abort the operation with no done pulse.
REQ-026 start SHALL be ignored in the cycle in which rst is high.

Configuration
REQ-027 Macro CMPLX_DIV_ROUND_EN SHALL select the rounding mode.
REQ-028 With the macro defined, the dividend SHALL be |num| << 5 divided over 13 iterations; the result SHALL then be rounded half away from zero to 4 fraction bits.
REQ-029 With the macro defined, normal latency SHALL be done in the cycle after edge N+27; zero-divisor latency is unchanged.
REQ-030 Without the macro, truncation and the REQ-017 latency SHALL apply.

Structure
REQ-031 Package cmplx_div_pkg SHALL hold IN_W=4, OUT_W=9, FRAC_BITS=4, ITERS (12, or 13 with rounding), the state enumeration and the den width.
REQ-032 Sub-module seq_udiv SHALL be an unsigned restoring divider with load/iterate controls, one quotient bit per cycle, shared between DIV_R and DIV_I.

Verification
REQ-033 a=3, b=2, c=1, d=1, start at edge N -> done after edge N+25, z_r=40 (2.5), z_i=-8 (0x1F8), div_zero=0.
REQ-034 a=2, b=0, c=3, d=0 -> z_r=10 (truncate), or 11 with CMPLX_DIV_ROUND_EN defined; z_i=0.
REQ-035 a=5, b=-3, c=0, d=0 -> done after edge N+1, z_r=z_i=0, div_zero=1; a following normal op clears div_zero.
REQ-036 a=-8, b=-8, c=1, d=0 -> z_r=-128, z_i=-128; then start pulsed while busy -> ignored, exactly one done.
REQ-037 rst asserted 10 cycles into an op -> no done, all outputs 0 next cycle; a new start then completes with normal latency.
